// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU input sequencer and the ALU it feeds.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/alu.sv
// Shared combinational ALU: operands A/B and a 6-bit opcode in, result out.
module alu
    import alu_seq_pkg::*;
#(
    parameter int NB_IN   = 8,
    parameter int NB_OUT  = 8,
    parameter int NB_CODE = 6
) (
    input  logic [NB_IN-1:0]   i_a,
    input  logic [NB_IN-1:0]   i_b,
    input  logic [NB_CODE-1:0] i_code,
    output logic [NB_OUT-1:0]  o_result
);

    logic [NB_IN-1:0] res_s;

    // Opcode decode; unknown opcodes yield zero.
    always_comb begin
        res_s = {NB_IN{1'b0}};
        case (i_code)
            OP_ADD:  res_s = i_a + i_b;
            OP_SUB:  res_s = i_a - i_b;
            OP_AND:  res_s = i_a & i_b;
            OP_OR:   res_s = i_a | i_b;
            OP_XOR:  res_s = i_a ^ i_b;
            OP_NOR:  res_s = ~(i_a | i_b);
            OP_SRA:  res_s = $signed(i_a) >>> i_b;
            OP_SRL:  res_s = i_a >> i_b;
            default: res_s = {NB_IN{1'b0}};
        endcase
    end

    assign o_result = NB_OUT'(res_s);

endmodule

// File: rtl/button_cond.sv
// Push-button conditioner: 2-FF synchronizer, optional debounce (DEBOUNCE_EN), registered rising-edge pulse.
module button_cond #(
    parameter int DB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic       sync1_q, sync2_q, prev_q, armed_q, pulse_q;
    logic [1:0] fill_q;
    logic       level_s, armed_d, pulse_d;

`ifdef DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Flip the debounced level only after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                deb_d = sync2_q;
                cnt_d = {CW{1'b0}};
            end else begin
                cnt_d = cnt_q + CW'(1'b1);
            end
        end else begin
            cnt_d = {CW{1'b0}};
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q <= 1'b0;
            cnt_q <= {CW{1'b0}};
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign level_s = deb_q;
`else
    localparam int unused_db_cycles = DB_CYCLES;
    assign level_s = sync2_q;
`endif

    // A button already held at reset release must be seen low before it may pulse.
    always_comb begin
        armed_d = armed_q | (fill_q[1] & ~sync2_q);
        pulse_d = armed_q & level_s & ~prev_q;
    end

    // Synchronizer, fill tracker, edge history and pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fill_q  <= 2'b00;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
            prev_q  <= level_s;
            armed_q <= armed_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_pulse = pulse_q;

endmodule

// File: rtl/alu_input_sequencer.sv
// Ordered A/B/opcode loader in front of the shared alu; optional DEBOUNCE_EN enables button debounce.
module alu_input_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NB_SW     = 8,
    parameter int NB_DATA   = 8,
    parameter int NB_CODE   = 6,
    parameter int DB_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NB_SW-1:0]   switch,
    input  logic               b_dato1,
    input  logic               b_dato2,
    input  logic               b_code,
    input  logic               b_clear,
    output logic [NB_DATA-1:0] o_salida,
    output logic               o_valid,
    output logic               o_error,
    output logic [2:0]         o_state
);

    logic               p_dato1_s, p_dato2_s, p_code_s, p_clear_s, multi_s;
    logic [NB_DATA-1:0] sw_data_s, alu_res_s;

    state_t             state_q, state_d;
    logic [NB_DATA-1:0] dato1_q, dato1_d, dato2_q, dato2_d, salida_q, salida_d;
    logic [NB_CODE-1:0] code_q, code_d;
    logic               valid_q, valid_d, error_q, error_d;

    button_cond #(.DB_CYCLES(DB_CYCLES)) u_bc_dato1 (.clk(clk), .rst_n(rst_n), .i_btn(b_dato1), .o_pulse(p_dato1_s));
    button_cond #(.DB_CYCLES(DB_CYCLES)) u_bc_dato2 (.clk(clk), .rst_n(rst_n), .i_btn(b_dato2), .o_pulse(p_dato2_s));
    button_cond #(.DB_CYCLES(DB_CYCLES)) u_bc_code  (.clk(clk), .rst_n(rst_n), .i_btn(b_code),  .o_pulse(p_code_s));
    button_cond #(.DB_CYCLES(DB_CYCLES)) u_bc_clear (.clk(clk), .rst_n(rst_n), .i_btn(b_clear), .o_pulse(p_clear_s));

    if (NB_SW >= NB_DATA) begin : g_sw_trunc
        assign sw_data_s = switch[NB_DATA-1:0];
    end else begin : g_sw_ext
        assign sw_data_s = {{(NB_DATA-NB_SW){1'b0}}, switch};
    end

    alu #(.NB_IN(NB_DATA), .NB_OUT(NB_DATA), .NB_CODE(NB_CODE)) u_alu (
        .i_a      (dato1_q),
        .i_b      (dato2_q),
        .i_code   (code_q),
        .o_result (alu_res_s)
    );

    assign multi_s = (p_dato1_s & p_dato2_s) | (p_dato1_s & p_code_s) | (p_dato2_s & p_code_s);

    // Next-state and output decisions; clear dominates, simultaneous load pulses are rejected.
    always_comb begin
        state_d  = state_q;
        dato1_d  = dato1_q;
        dato2_d  = dato2_q;
        code_d   = code_q;
        salida_d = salida_q;
        valid_d  = valid_q;
        error_d  = error_q;
        if (p_clear_s) begin
            state_d  = WAIT_A;
            dato1_d  = {NB_DATA{1'b0}};
            dato2_d  = {NB_DATA{1'b0}};
            code_d   = {NB_CODE{1'b0}};
            salida_d = {NB_DATA{1'b0}};
            valid_d  = 1'b0;
            error_d  = 1'b0;
        end else if (multi_s) begin
            error_d = 1'b1;
        end else begin
            case (state_q)
                WAIT_A: begin
                    if (p_dato1_s) begin
                        dato1_d = sw_data_s;
                        error_d = 1'b0;
                        state_d = WAIT_B;
                    end else if (p_dato2_s | p_code_s) begin
                        error_d = 1'b1;
                    end else begin
                        state_d = WAIT_A;
                    end
                end
                WAIT_B: begin
                    if (p_dato2_s) begin
                        dato2_d = sw_data_s;
                        error_d = 1'b0;
                        state_d = WAIT_OP;
                    end else if (p_dato1_s | p_code_s) begin
                        error_d = 1'b1;
                    end else begin
                        state_d = WAIT_B;
                    end
                end
                WAIT_OP: begin
                    if (p_code_s) begin
                        code_d  = switch[NB_CODE-1:0];
                        error_d = 1'b0;
                        state_d = EXEC;
                    end else if (p_dato1_s | p_dato2_s) begin
                        error_d = 1'b1;
                    end else begin
                        state_d = WAIT_OP;
                    end
                end
                EXEC: begin
                    salida_d = alu_res_s;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                    if (p_dato1_s | p_dato2_s | p_code_s) begin
                        error_d = 1'b1;
                    end else begin
                        error_d = error_q;
                    end
                end
                DONE: begin
                    if (p_code_s) begin
                        code_d  = switch[NB_CODE-1:0];
                        error_d = 1'b0;
                        state_d = EXEC;
                    end else if (p_dato1_s) begin
                        dato1_d = sw_data_s;
                        valid_d = 1'b0;
                        error_d = 1'b0;
                        state_d = WAIT_B;
                    end else if (p_dato2_s) begin
                        error_d = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = WAIT_A;
                end
            endcase
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_A;
            dato1_q  <= {NB_DATA{1'b0}};
            dato2_q  <= {NB_DATA{1'b0}};
            code_q   <= {NB_CODE{1'b0}};
            salida_q <= {NB_DATA{1'b0}};
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dato1_q  <= dato1_d;
            dato2_q  <= dato2_d;
            code_q   <= code_d;
            salida_q <= salida_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    assign o_salida = salida_q;
    assign o_valid  = valid_q;
    assign o_error  = error_q;
    assign o_state  = state_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer; the DEBOUNCE_EN build uses DB_CYCLES=4.
module tb_alu_input_sequencer;

`ifdef DEBOUNCE_EN
    localparam int TB_DB = 4;
    localparam int EXTRA = 4;
`else
    localparam int TB_DB = 1000;
    localparam int EXTRA = 0;
`endif

    localparam logic [3:0] BT_D1  = 4'b0001;
    localparam logic [3:0] BT_D2  = 4'b0010;
    localparam logic [3:0] BT_OP  = 4'b0100;
    localparam logic [3:0] BT_CLR = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] switch = 8'h00;
    logic       b_dato1 = 1'b0, b_dato2 = 1'b0, b_code = 1'b0, b_clear = 1'b0;
    logic [7:0] o_salida;
    logic       o_valid, o_error;
    logic [2:0] o_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_input_sequencer #(.NB_SW(8), .NB_DATA(8), .NB_CODE(6), .DB_CYCLES(TB_DB)) dut (
        .clk(clk), .rst_n(rst_n), .switch(switch),
        .b_dato1(b_dato1), .b_dato2(b_dato2), .b_code(b_code), .b_clear(b_clear),
        .o_salida(o_salida), .o_valid(o_valid), .o_error(o_error), .o_state(o_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise buttons before edge n, release after the pulse registers, return just after the load edge n+3.
    task automatic press(input logic [3:0] b, input logic [7:0] sw);
        @(negedge clk);
        switch = sw;
        {b_clear, b_code, b_dato2, b_dato1} = b;
        repeat (3 + EXTRA) @(posedge clk);
        @(negedge clk);
        {b_clear, b_code, b_dato2, b_dato1} = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        idle(2);
        chk("rst_state",  32'(o_state),  32'd0);
        chk("rst_salida", 32'(o_salida), 32'h00);
        chk("rst_valid",  32'(o_valid),  32'd0);
        chk("rst_error",  32'(o_error),  32'd0);
        rst_n = 1'b1;
        idle(4);

        // 5 + 3 = 8, result two edges after the code pulse
        press(BT_D1, 8'h05); chk("ldA_state", 32'(o_state), 32'd1); idle(2 + EXTRA);
        press(BT_D2, 8'h03); chk("ldB_state", 32'(o_state), 32'd2); idle(2 + EXTRA);
        press(BT_OP, 8'h20);
        chk("exec_state", 32'(o_state), 32'd3);
        chk("exec_valid", 32'(o_valid), 32'd0);
        idle(1);
        chk("add_state",  32'(o_state),  32'd4);
        chk("add_valid",  32'(o_valid),  32'd1);
        chk("add_salida", 32'(o_salida), 32'h08);
        idle(2 + EXTRA);

        // Re-execute with SUB: valid stays high throughout
        press(BT_OP, 8'h22);
        chk("sub_exec_valid", 32'(o_valid), 32'd1);
        idle(1);
        chk("sub_salida", 32'(o_salida), 32'h02);
        chk("sub_valid",  32'(o_valid),  32'd1);
        idle(2 + EXTRA);

        press(BT_D1, 8'hF0);
        chk("reloadA_state", 32'(o_state),  32'd1);
        chk("reloadA_valid", 32'(o_valid),  32'd0);
        chk("reloadA_hold",  32'(o_salida), 32'h02);
        idle(2 + EXTRA);

        press(BT_CLR, 8'h00);
        chk("clr1_state",  32'(o_state),  32'd0);
        chk("clr1_salida", 32'(o_salida), 32'h00);
        idle(2 + EXTRA);

        // Wrong button in WAIT_A, then a valid load clears the flag
        press(BT_OP, 8'h20);
        chk("wrong_error", 32'(o_error), 32'd1);
        chk("wrong_state", 32'(o_state), 32'd0);
        idle(2 + EXTRA);
        press(BT_D1, 8'h11);
        chk("recover_error", 32'(o_error), 32'd0);
        chk("recover_state", 32'(o_state), 32'd1);
        idle(2 + EXTRA);

        press(BT_CLR, 8'h00); idle(2 + EXTRA);
        press(BT_D1 | BT_D2, 8'h33);
        chk("dual_error", 32'(o_error), 32'd1);
        chk("dual_state", 32'(o_state), 32'd0);
        idle(2 + EXTRA);
        press(BT_CLR, 8'h00);
        chk("clr2_error", 32'(o_error), 32'd0);
        idle(2 + EXTRA);

        // Clear from WAIT_OP, then a fresh computation: 0x12 + 0x34 = 0x46
        press(BT_D1, 8'h7F); idle(2 + EXTRA);
        press(BT_D2, 8'h01);
        chk("wop_state", 32'(o_state), 32'd2);
        idle(2 + EXTRA);
        press(BT_CLR, 8'h00);
        chk("clr3_state",  32'(o_state),  32'd0);
        chk("clr3_salida", 32'(o_salida), 32'h00);
        chk("clr3_valid",  32'(o_valid),  32'd0);
        idle(2 + EXTRA);
        press(BT_D1, 8'h12); idle(2 + EXTRA);
        press(BT_D2, 8'h34); idle(2 + EXTRA);
        press(BT_OP, 8'h20); idle(1);
        chk("add2_salida", 32'(o_salida), 32'h46);
        idle(2 + EXTRA);
        press(BT_OP, 8'h24); idle(1);
        chk("and_salida", 32'(o_salida), 32'h10);
        idle(2 + EXTRA);
        press(BT_OP, 8'h26); idle(1);
        chk("xor_salida", 32'(o_salida), 32'h26);
        idle(2 + EXTRA);
        press(BT_OP, 8'h27); idle(1);
        chk("nor_salida", 32'(o_salida), 32'hC9);
        idle(2 + EXTRA);

        // dato2 in DONE is an error only
        press(BT_D2, 8'h99);
        chk("done_d2_error",  32'(o_error),  32'd1);
        chk("done_d2_state",  32'(o_state),  32'd4);
        chk("done_d2_salida", 32'(o_salida), 32'hC9);
        idle(2 + EXTRA);

        // Reset in the middle of EXEC, with dato1 held across release
        press(BT_OP, 8'h20);
        chk("pre_rst_state", 32'(o_state), 32'd3);
        rst_n = 1'b0;
        b_dato1 = 1'b1;
        #1;
        chk("mid_rst_state",  32'(o_state),  32'd0);
        chk("mid_rst_salida", 32'(o_salida), 32'h00);
        chk("mid_rst_valid",  32'(o_valid),  32'd0);
        chk("mid_rst_error",  32'(o_error),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(8 + 2 * EXTRA);
        chk("held_state", 32'(o_state), 32'd0);
        chk("held_error", 32'(o_error), 32'd0);
        b_dato1 = 1'b0;
        idle(4 + EXTRA);
        press(BT_D1, 8'h01);
        chk("post_rst_ldA", 32'(o_state), 32'd1);
        idle(2 + EXTRA);

`ifdef DEBOUNCE_EN
        // A 3-cycle glitch on dato2 in WAIT_B must not load
        @(negedge clk);
        b_dato2 = 1'b1;
        idle(3);
        b_dato2 = 1'b0;
        idle(12);
        chk("glitch_state", 32'(o_state), 32'd1);
        chk("glitch_error", 32'(o_error), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
